// File: rtl/mlp_result_streamer.sv
// Return-path framer: snapshots MLP status on a host request or on inference completion
// and streams it as a 7-byte checksummed frame over a valid/ready byte interface.
module mlp_result_streamer #(
    parameter logic [7:0] HEADER_BYTE  = 8'hA5,
    parameter logic [2:0] DONE_STATE   = 3'd6,
    parameter bit         AUTO_ON_DONE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic [2:0]  mlp_state,
    input  logic [4:0]  mlp_cycle_cnt,
    input  logic [31:0] mlp_acc0,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    typedef enum logic {StIdle, StSend} state_e;

    state_e      state_q, state_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  shadow_state_q;
    logic [4:0]  shadow_cnt_q;
    logic [31:0] shadow_acc_q;
    logic [2:0]  prev_state_q;
    logic        frame_done_q, frame_done_d;
    logic        overrun_q, overrun_d;
    logic        capture;
    logic        auto_trig, trig;
    logic [7:0]  status_byte, checksum;

    // Auto trigger fires only on the edge into the done state, not while it is held.
    assign auto_trig = AUTO_ON_DONE && (mlp_state == DONE_STATE)
                       && (prev_state_q != DONE_STATE);
    assign trig      = rd_req | auto_trig;

    assign status_byte = {shadow_state_q, shadow_cnt_q};
    assign checksum    = status_byte ^ shadow_acc_q[7:0] ^ shadow_acc_q[15:8]
                         ^ shadow_acc_q[23:16] ^ shadow_acc_q[31:24];

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        capture      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    capture    = 1'b1;
                    byte_idx_d = 3'd0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (trig) begin
                    overrun_d = 1'b1;
                end
                if (tx_ready) begin
                    if (byte_idx_q == 3'd6) begin
                        byte_idx_d   = 3'd0;
                        frame_done_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_data = 8'h00;
        if (state_q == StSend) begin
            unique case (byte_idx_q)
                3'd0:    tx_data = HEADER_BYTE;
                3'd1:    tx_data = status_byte;
                3'd2:    tx_data = shadow_acc_q[7:0];
                3'd3:    tx_data = shadow_acc_q[15:8];
                3'd4:    tx_data = shadow_acc_q[23:16];
                3'd5:    tx_data = shadow_acc_q[31:24];
                3'd6:    tx_data = checksum;
                default: tx_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            byte_idx_q     <= 3'd0;
            shadow_state_q <= 3'd0;
            shadow_cnt_q   <= 5'd0;
            shadow_acc_q   <= 32'd0;
            prev_state_q   <= 3'd0;
            frame_done_q   <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            prev_state_q <= mlp_state;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            if (capture) begin
                shadow_state_q <= mlp_state;
                shadow_cnt_q   <= mlp_cycle_cnt;
                shadow_acc_q   <= mlp_acc0;
            end
        end
    end

    assign tx_valid   = (state_q == StSend);
    assign busy       = (state_q == StSend);
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_mlp_result_streamer.sv
// Randomised bench for mlp_result_streamer against a queue-based frame model.
module tb_mlp_result_streamer;

    localparam logic [7:0] Header    = 8'hA5;
    localparam logic [2:0] DoneState = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req;
    logic [2:0]  mlp_state;
    logic [4:0]  mlp_cycle_cnt;
    logic [31:0] mlp_acc0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int          n_checks = 0;
    int          n_errors = 0;
    int          dut_frames = 0;
    int          model_frames = 0;
    logic [7:0]  last_data;

    // Reference model: pending bytes of the current frame, plus flags.
    logic [7:0]  want_q[$];
    logic        m_done;
    logic        m_overrun;
    logic [2:0]  m_prev;

    mlp_result_streamer #(
        .HEADER_BYTE  (Header),
        .DONE_STATE   (DoneState),
        .AUTO_ON_DONE (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_req        (rd_req),
        .mlp_state     (mlp_state),
        .mlp_cycle_cnt (mlp_cycle_cnt),
        .mlp_acc0      (mlp_acc0),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic void build_frame(input logic [2:0] st, input logic [4:0] cnt,
                                        input logic [31:0] acc);
        int b [7];
        b[0] = int'(Header);
        b[1] = int'(st) * 32 + int'(cnt);
        for (int k = 0; k < 4; k++) b[2 + k] = int'((acc >> (8 * k)) & 32'hFF);
        b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        for (int k = 0; k < 7; k++) want_q.push_back(8'(b[k]));
    endfunction

    function automatic void model_clear();
        want_q.delete();
        m_done    = 1'b0;
        m_overrun = 1'b0;
        m_prev    = 3'd0;
    endfunction

    // One clock: compare outputs mid-cycle, advance the model, return just after the edge.
    task automatic tick();
        bit trig;
        bit active;
        @(negedge clk);
        active = (want_q.size() != 0);
        check_eq("tx_valid", tx_valid, active);
        check_eq("busy", busy, active);
        if (active) check_eq("tx_data", tx_data, want_q[0]);
        check_eq("frame_done", frame_done, m_done);
        check_eq("overrun", overrun, m_overrun);
        last_data = tx_data;
        if (frame_done) dut_frames++;
        if (rst_n) begin
            trig   = rd_req || (mlp_state == DoneState && m_prev != DoneState);
            m_done = active && tx_ready && (want_q.size() == 1);
            if (m_done) model_frames++;
            if (active) begin
                if (trig) m_overrun = 1'b1;
                if (tx_ready) void'(want_q.pop_front());
            end else if (trig) begin
                build_frame(mlp_state, mlp_cycle_cnt, mlp_acc0);
            end
            m_prev = mlp_state;
        end
        @(posedge clk);
        #1;
    endtask

    logic [7:0] t1_bytes [7] = '{8'hA5, 8'hC9, 8'h78, 8'h56, 8'h34, 8'h12, 8'hC1};
    int f0;

    initial begin
        rst_n         = 1'b0;
        rd_req        = 1'b0;
        mlp_state     = 3'd0;
        mlp_cycle_cnt = 5'd0;
        mlp_acc0      = 32'd0;
        tx_ready      = 1'b0;
        model_clear();
        #3;
        check_eq("rst_tx_valid", tx_valid, 1'b0);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_frame_done", frame_done, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Directed frame; request and auto event coincide, giving one frame.
        mlp_state     = 3'd6;
        mlp_cycle_cnt = 5'd9;
        mlp_acc0      = 32'h12345678;
        tx_ready      = 1'b1;
        rd_req        = 1'b1;
        f0            = dut_frames;
        tick();
        rd_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_eq("t1_byte", last_data, t1_bytes[i]);
        end
        tick();
        check_eq("t1_frames", dut_frames - f0, 1);
        repeat (3) tick();

        // Auto trigger on entering the done state, once only while held.
        mlp_state = 3'd5;
        repeat (3) tick();
        f0        = dut_frames;
        mlp_state = 3'd6;
        mlp_acc0  = $urandom;
        repeat (50) tick();
        check_eq("t2_frames", dut_frames - f0, 1);
        mlp_state = 3'd0;
        tick();

        // Inputs churn mid-frame; frame must reflect the captured snapshot.
        mlp_state     = 3'd2;
        mlp_cycle_cnt = 5'd17;
        mlp_acc0      = $urandom;
        rd_req        = 1'b1;
        tick();
        rd_req = 1'b0;
        repeat (9) begin
            mlp_acc0      = $urandom;
            mlp_cycle_cnt = 5'($urandom);
            tick();
        end

        // Requests mid-frame and on the final handshake are dropped.
        check_eq("t4_overrun_pre", overrun, 1'b0);
        f0     = dut_frames;
        rd_req = 1'b1;
        tick();
        for (int k = 1; k <= 7; k++) begin
            rd_req = (k == 3 || k == 7);
            tick();
        end
        rd_req = 1'b0;
        repeat (3) tick();
        check_eq("t4_frames", dut_frames - f0, 1);
        check_eq("t4_overrun", overrun, 1'b1);

        // Random backpressure and sparse requests with acc0 = -1.
        mlp_acc0 = 32'hFFFF_FFFF;
        repeat (400) begin
            tx_ready      = 1'($urandom_range(0, 1));
            rd_req        = ($urandom_range(0, 19) == 0);
            mlp_state     = 3'($urandom_range(0, 5));
            mlp_cycle_cnt = 5'($urandom);
            tick();
        end
        rd_req   = 1'b0;
        tx_ready = 1'b1;
        repeat (10) tick();
        check_eq("t3_frames", dut_frames, model_frames);

        // Reset while byte 3 is on the bus.
        mlp_state = 3'd0;
        mlp_acc0  = $urandom;
        rd_req    = 1'b1;
        tick();
        rd_req = 1'b0;
        repeat (3) tick();
        check_eq("t6_pre_byte", tx_data, want_q[0]);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_tx_valid", tx_valid, 1'b0);
        check_eq("t6_busy", busy, 1'b0);
        check_eq("t6_frame_done", frame_done, 1'b0);
        model_clear();
        f0 = dut_frames;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check_eq("t6_no_done", dut_frames - f0, 0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        check_eq("t6_header", last_data, Header);
        repeat (7) tick();
        check_eq("t6_frames", dut_frames - f0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
